// File: rtl/hack_seq.sv
// hack_seq: multi-cycle control sequencer for the Hack CPU datapath.
// Steps each instruction through FETCH -> DECODE -> (MEM) -> EXEC. It holds a
// private copy of the instruction word and resolves jumps from ALU flags.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   instr[15:0]      ROM instruction word, valid with imem_ack
//   imem_ack         ROM acknowledge
//   dmem_ack         RAM acknowledge (read data valid / write accepted)
//   zr, ng           ALU zero / negative flags for the current computation
//   halt_req         stop at the next instruction boundary
//   pc_reset/load/inc  program counter strobes
//   imem_req         ROM read request
//   ir_load          instruction register enable
//   a_load, d_load   A / D register enables
//   dmem_req/we      RAM request / write enable
//   state[2:0]       current state (debug)
//   halted           high in HALT
module hack_seq #(
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        zr,
  input  logic        ng,
  input  logic        halt_req,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        imem_req,
  output logic        ir_load,
  output logic        a_load,
  output logic        d_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(RESET_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_boot_cnt;
  logic [15:0] r_ir;
  logic        w_jump;
  logic        w_exec_done;
  logic        w_unused_ir;

  // Only the type, a-bit, dest and jump fields steer the sequencer.
  assign w_unused_ir = ^{r_ir[14:13], r_ir[11:6]};

  assign w_jump = (r_ir[2] & ng) | (r_ir[1] & zr) | (r_ir[0] & ~ng & ~zr);
  // A memory write must be accepted before the instruction can retire.
  assign w_exec_done = ~r_ir[3] | dmem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
      r_ir       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_BOOT) r_boot_cnt <= r_boot_cnt + 4'd1;
      else                   r_boot_cnt <= '0;
      if ((r_state == S_FETCH) && imem_ack) r_ir <= instr;
    end
  end

  always_comb begin
    w_next   = r_state;
    pc_reset = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    a_load   = 1'b0;
    d_load   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_BOOT: begin
        pc_reset = 1'b1;
        if (r_boot_cnt >= BOOT_LAST) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!r_ir[15]) begin
          a_load = 1'b1;
          pc_inc = 1'b1;
          w_next = halt_req ? S_HALT : S_FETCH;
        end else begin
          w_next = r_ir[12] ? S_MEM : S_EXEC;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        dmem_req = r_ir[3];
        dmem_we  = r_ir[3];
        if (w_exec_done) begin
          d_load  = r_ir[4];
          a_load  = r_ir[5];
          pc_load = w_jump;
          pc_inc  = ~w_jump;
          w_next  = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_BOOT;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_hack_seq.sv
module tb_hack_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_reset, pc_load, pc_inc, imem_req, ir_load;
  logic        a_load, d_load, dmem_req, dmem_we, halted;
  logic [2:0]  state;

  hack_seq #(.RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .zr(zr), .ng(ng), .halt_req(halt_req),
    .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc),
    .imem_req(imem_req), .ir_load(ir_load), .a_load(a_load),
    .d_load(d_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {halted, dmem_we, dmem_req, d_load, a_load,
  // ir_load, imem_req, pc_inc, pc_load, pc_reset, state[2:0]}
  logic [12:0] w_obs;
  assign w_obs = {halted, dmem_we, dmem_req, d_load, a_load, ir_load,
                  imem_req, pc_inc, pc_load, pc_reset, state};

  localparam logic [12:0] SB = 13'd0, SF = 13'd1, SD = 13'd2, SM = 13'd3,
                          SE = 13'd4, SH = 13'd5;
  localparam logic [12:0] PCR = 13'h008, PCL = 13'h010, PCI = 13'h020,
                          IMR = 13'h040, IRL = 13'h080, AL  = 13'h100,
                          DL  = 13'h200, DMR = 13'h400, DMW = 13'h800,
                          HLT = 13'h1000;

  logic [12:0] sb_q[$];
  logic [12:0] exp_v;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Stimulus vector {reset, instr, imem_ack, dmem_ack, zr, ng, halt_req}
  function automatic logic [21:0] v(input logic r, input logic [15:0] ins,
                                    input logic ia, input logic da,
                                    input logic z, input logic n,
                                    input logic h);
    return {r, ins, ia, da, z, n, h};
  endfunction

  task automatic drive(input logic [21:0] s, input logic [12:0] e);
    @(negedge clk);
    {reset, instr, imem_ack, dmem_ack, zr, ng, halt_req} = s;
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    logic [21:0] st [6];
    logic [12:0] ex [6];
    st = '{v(0,16'hFFFF,1,1,1,1,1), v(0,16'h0000,1,1,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SB|PCR, SB|PCR, SB|PCR, SB|PCR, SF|IMR, SF|IMR};
    for (int i = 0; i < 6; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_a_instr;
    logic [21:0] st [3];
    logic [12:0] ex [3];
    // instr is driven to garbage after the ack so DECODE must use its own copy
    st = '{v(1,16'h0005,1,0,0,0,0), v(1,16'hFFFF,0,1,1,1,0),
           v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD|AL|PCI, SF|IMR};
    for (int i = 0; i < 3; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL a_instr[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_c_nomem;
    logic [21:0] st [4];
    logic [12:0] ex [4];
    st = '{v(1,16'hEC10,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD, SE|DL|PCI, SF|IMR};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL c_nomem[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_c_mem;
    logic [21:0] st [8];
    logic [12:0] ex [8];
    st = '{v(1,16'hFC88,1,0,0,0,0), v(1,16'h0000,0,1,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,1,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,1,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD, SM|DMR, SM|DMR, SM|DMR, SE|DMR|DMW,
           SE|DMR|DMW|PCI, SF|IMR};
    for (int i = 0; i < 8; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL c_mem[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_jumps;
    logic [21:0] st [13];
    logic [12:0] ex [13];
    st = '{v(1,16'hE302,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,1,0,0),
           v(1,16'hE302,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,1,0),
           v(1,16'hE302,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0),
           v(1,16'hEA87,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD, SE|PCL,
           SF|IMR|IRL, SD, SE|PCI,
           SF|IMR|IRL, SD, SE|PCI,
           SF|IMR|IRL, SD, SE|PCL, SF|IMR};
    for (int i = 0; i < 13; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL jumps[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_halt;
    logic [21:0] st [9];
    logic [12:0] ex [9];
    st = '{v(1,16'h0005,1,0,0,0,1), v(1,16'h0000,0,0,0,0,1),
           v(1,16'h1234,1,1,1,0,0), v(1,16'hEC10,1,1,0,1,0),
           v(1,16'h0000,1,0,0,0,0), v(0,16'h0000,1,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD|AL|PCI, SH|HLT, SH|HLT, SH|HLT, SB|PCR,
           SB|PCR, SB|PCR, SF|IMR};
    for (int i = 0; i < 9; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL halt[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_exec;
    logic [21:0] st [4];
    logic [12:0] ex [4];
    st = '{v(1,16'hFC88,1,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,1,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SF|IMR|IRL, SD, SM|DMR, SE|DMR|DMW};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL mid_exec[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
    // Assert reset between clock edges; outputs must collapse at once.
    #1;
    reset = 1'b0;
    dmem_ack = 1'b1;
    sb_q.push_back(SB|PCR);
    #1;
    exp_v = sb_q.pop_front();
    n_vec++;
    if (w_obs !== exp_v) begin
      n_err++;
      $display("FAIL mid_exec_async: got %h expected %h", w_obs, exp_v);
    end
    // Boot again and confirm the cleared ir does not leak into a fetch.
    st = '{v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0),
           v(1,16'h0000,0,0,0,0,0), v(1,16'h0000,0,0,0,0,0)};
    ex = '{SB|PCR, SB|PCR, SF|IMR, SF|IMR};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      #2;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL reboot[%0d]: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_instr();
    test_c_nomem();
    test_c_mem();
    test_jumps();
    test_halt();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
